// File: rtl/icache_pkg.sv
// Shared types and widths for the direct-mapped instruction cache controller.
package icache_pkg;

    localparam int BLOCK_W    = 128;
    localparam int MEM_ADDR_W = 28;
    localparam int WORD_W     = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Word 0 of a block sits in the least significant bits.
    function automatic logic [WORD_W-1:0] select_word(input logic [BLOCK_W-1:0] block,
                                                      input logic [1:0]         word);
        logic [WORD_W-1:0] result;
        case (word)
            2'd0:    result = block[WORD_W-1:0];
            2'd1:    result = block[2*WORD_W-1:WORD_W];
            2'd2:    result = block[3*WORD_W-1:2*WORD_W];
            default: result = block[4*WORD_W-1:3*WORD_W];
        endcase
        return result;
    endfunction

endpackage

// File: rtl/icache_data_array.sv
// Line storage for the instruction cache: data, tag and valid per line,
// one synchronous write port and a combinational read port.
module icache_data_array
    import icache_pkg::*;
#(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = MEM_ADDR_W - INDEX_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               write_en,
    input  logic [INDEX_W-1:0] write_index,
    input  logic [TAG_W-1:0]   write_tag,
    input  logic [BLOCK_W-1:0] write_data,
    input  logic [INDEX_W-1:0] read_index,
    output logic [TAG_W-1:0]   read_tag,
    output logic [BLOCK_W-1:0] read_data,
    output logic               read_valid
);

    localparam int LINES = 2 ** INDEX_W;

    logic [BLOCK_W-1:0] data_mem [LINES];
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [LINES-1:0]   valid;

    // Only the valid bits are reset; stale data/tag are masked by valid=0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (write_en) begin
            valid[write_index] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (write_en) begin
            data_mem[write_index] <= write_data;
            tag_mem[write_index]  <= write_tag;
        end
    end

    assign read_tag   = tag_mem[read_index];
    assign read_data  = data_mem[read_index];
    assign read_valid = valid[read_index];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller (IDLE -> FETCH -> UPDATE on miss).
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int INDEX_W = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_read,
    input  logic [31:0]           cpu_address,
    output logic [WORD_W-1:0]     cpu_instr,
    output logic                  cpu_busywait,
    output logic                  mem_read,
    output logic [MEM_ADDR_W-1:0] mem_address,
    input  logic [BLOCK_W-1:0]    mem_readdata,
    input  logic                  mem_busywait
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int TAG_W = MEM_ADDR_W - INDEX_W;

    // Handshake: a fetch is accepted only when cpu_busywait is low in the
    // cycle cpu_read is high; memory data is taken on the first edge with
    // mem_busywait low after it has been seen high during FETCH.

    state_t state;
    state_t state_next;

    logic [TAG_W-1:0]      addr_tag;
    logic [INDEX_W-1:0]    addr_index;
    logic [1:0]            addr_word;
    logic [MEM_ADDR_W-1:0] addr_block;
    logic [1:0]            unused_byte;

    logic [TAG_W-1:0]      line_tag;
    logic [BLOCK_W-1:0]    line_data;
    logic                  line_valid;
    logic                  hit;
    logic                  miss;

    logic                  seen_busy;
    logic                  fetch_done;
    logic [MEM_ADDR_W-1:0] fill_block;
    logic [BLOCK_W-1:0]    hold_data;
    logic                  write_en;

    assign addr_tag    = cpu_address[31:4+INDEX_W];
    assign addr_index  = cpu_address[3+INDEX_W:4];
    assign addr_word   = cpu_address[3:2];
    assign addr_block  = cpu_address[31:4];
    assign unused_byte = cpu_address[1:0];

    icache_data_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_data_array (
        .clock       (clock),
        .reset       (reset),
        .write_en    (write_en),
        .write_index (fill_block[INDEX_W-1:0]),
        .write_tag   (fill_block[MEM_ADDR_W-1:INDEX_W]),
        .write_data  (hold_data),
        .read_index  (addr_index),
        .read_tag    (line_tag),
        .read_data   (line_data),
        .read_valid  (line_valid)
    );

    assign hit        = line_valid && (line_tag == addr_tag);
    assign miss       = (state == IDLE) && cpu_read && !hit;
    assign fetch_done = (state == FETCH) && seen_busy && !mem_busywait;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (miss) state_next = FETCH;
            FETCH:   if (fetch_done) state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cpu_instr    = '0;
        cpu_busywait = 1'b0;
        mem_read     = 1'b0;
        mem_address  = '0;
        write_en     = 1'b0;
        case (state)
            IDLE: begin
                cpu_busywait = cpu_read && !hit;
                if (cpu_read && hit) begin
                    cpu_instr = select_word(line_data, addr_word);
                end
            end
            FETCH: begin
                cpu_busywait = 1'b1;
                mem_read     = 1'b1;
                mem_address  = fill_block;
            end
            UPDATE: begin
                cpu_busywait = 1'b1;
                write_en     = 1'b1;
            end
            default: ;
        endcase
    end

    // The fill target is frozen at the miss so later address changes cannot redirect it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seen_busy  <= 1'b0;
            fill_block <= '0;
            hold_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    seen_busy <= 1'b0;
                    if (miss) fill_block <= addr_block;
                end
                FETCH: begin
                    if (mem_busywait) seen_busy <= 1'b1;
                    if (fetch_done) hold_data <= mem_readdata;
                end
                default: seen_busy <= 1'b0;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && cpu_read) begin
            if (hit) begin
                if (hit_count != '1) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != '1) miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
